memory_module: RTL and testbench

- Consumer end of the CPU control word: the RAM plus memory address register (MAR) that acts on the MAI, MI and MO control bits driven each cycle by the control unit.
- Holds the 8-bit program and data store. Drives the shared bus on MO.
- Includes a byte-stream program loader (valid/ready) that fills RAM while holding the CPU off via halt.

---
 rtl/memory_module.sv | 130 +++++++++++++
 tb/tb_memory_module.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_module.sv
// RAM and memory address register driven by the MAI/MI/MO control bits, plus a
// valid/ready byte-stream program loader that fills RAM while halting the CPU.
module memory_module #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256  // must equal 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mai,
  input  logic                  mi,
  input  logic                  mo,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_oe,
  input  logic                  prog_start,
  input  logic [ADDR_WIDTH-1:0] prog_base,
  input  logic                  prog_valid,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  prog_last,
  output logic                  prog_ready,
  output logic                  halt,
  output logic                  prog_done,
  output logic [ADDR_WIDTH:0]   load_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] LOAD_MAX = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_load_count;
  logic                  r_halt;
  logic                  r_prog_ready;
  logic                  r_prog_done;
  logic [DATA_WIDTH-1:0] r_ram [DEPTH];

  logic                  w_idle;
  logic                  w_cpu_we;
  logic                  w_ld_accept;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  assign w_idle      = (r_state == S_IDLE);
  assign w_cpu_we    = w_idle && mi;
  assign w_ld_accept = (r_state == S_LOAD) && prog_valid && r_prog_ready;
  assign w_ram_we    = w_cpu_we || w_ld_accept;

  // CPU and loader writes live in disjoint FSM states, so one write port suffices.
  always_comb begin
    w_wr_addr = r_mar;
    w_wr_data = bus_in;
    if (w_ld_accept) begin
      w_wr_addr = r_ptr;
      w_wr_data = prog_data;
    end
  end

  // RAM is deliberately not reset so program contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mar        <= '0;
      r_ptr        <= '0;
      r_load_count <= '0;
      r_halt       <= 1'b0;
      r_prog_ready <= 1'b0;
      r_prog_done  <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mai) begin
            r_mar <= bus_in[ADDR_WIDTH-1:0];
          end
          if (prog_start) begin
            r_state      <= S_LOAD;
            r_ptr        <= prog_base;
            r_load_count <= '0;
            r_halt       <= 1'b1;
            r_prog_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_ld_accept) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_load_count != LOAD_MAX) begin
              r_load_count <= r_load_count + 1'b1;
            end
            if (prog_last) begin
              r_state      <= S_DONE;
              r_prog_ready <= 1'b0;
              r_prog_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_halt  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_halt       <= 1'b0;
          r_prog_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus_out    = r_ram[r_mar];
  assign bus_oe     = mo && w_idle;
  assign halt       = r_halt;
  assign prog_ready = r_prog_ready;
  assign prog_done  = r_prog_done;
  assign load_count = r_load_count;

endmodule

// File: tb/tb_memory_module.sv
// Randomized bench for memory_module against an array-based model of the RAM,
// MAR and loader rules.
module tb_memory_module;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, mai, mi, mo;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic          prog_start, prog_valid, prog_last;
  logic [AW-1:0] prog_base;
  logic [DW-1:0] prog_data;
  logic          prog_ready, halt, prog_done;
  logic [AW:0]   load_count;

  always #5 clk = ~clk;

  memory_module #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mai(mai), .mi(mi), .mo(mo), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .prog_start(prog_start),
    .prog_base(prog_base), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_last(prog_last), .prog_ready(prog_ready), .halt(halt),
    .prog_done(prog_done), .load_count(load_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [DW-1:0] m_ram   [DEPTH];
  bit            m_known [DEPTH];
  logic [AW-1:0] m_mar;
  logic [DW-1:0] ld_data [$];

  always @(negedge clk) if (prog_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mai = 0; mi = 0; mo = 0; bus_in = '0;
    prog_start = 0; prog_valid = 0; prog_last = 0; prog_base = '0; prog_data = '0;
  endtask

  task automatic cpu_op(input bit a, input bit w, input bit o, input logic [DW-1:0] d);
    mai = a; mi = w; mo = o; bus_in = d;
    tick();
    if (w) begin m_ram[m_mar] = d; m_known[m_mar] = 1; end
    if (a) m_mar = d[AW-1:0];
    mai = 0; mi = 0; mo = 0;
  endtask

  task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] d, output logic oe);
    cpu_op(1, 0, 0, DW'(addr));
    mo = 1;
    #1;
    d = bus_out; oe = bus_oe;
    mo = 0;
  endtask

  task automatic check_all_known();
    logic [DW-1:0] d;
    logic oe;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (m_known[a]) begin
        read_word(AW'(a), d, oe);
        vectors++;
        if (d !== m_ram[a] || oe !== 1'b1) begin
          miscompares++;
          $display("FAIL readback addr=%02h got=%02h oe=%b exp=%02h oe=1", a, d, oe, m_ram[a]);
        end
      end
    end
  endtask

  // Runs one load of ld_data from base; gap<0 gives random gaps; abort_after>0 resets after that many beats.
  task automatic run_load(input logic [AW-1:0] base, input int gap, input int abort_after,
                          input bit junk, input bit cpu_at_start, input logic [DW-1:0] cpu_val);
    int n = ld_data.size();
    int d0 = done_cnt;
    int exp_cnt;
    logic [AW-1:0] ptr = base;
    prog_start = 1; prog_base = base;
    if (cpu_at_start) begin mai = 1; mi = 1; bus_in = cpu_val; end
    #1;
    vectors++;
    if (halt !== 1'b0) begin miscompares++; $display("FAIL start_halt got=%b exp=0", halt); end
    tick();
    if (cpu_at_start) begin m_ram[m_mar] = cpu_val; m_known[m_mar] = 1; m_mar = cpu_val[AW-1:0]; end
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      int w = (i == 0) ? 0 : ((gap >= 0) ? gap : int'($urandom_range(0, 3)));
      for (int c = 0; c <= w; c++) begin
        bit beat = (c == w);
        prog_valid = beat; prog_data = ld_data[i]; prog_last = beat && (i == n - 1);
        if (junk) begin
          mai = 1; mi = 1; mo = 1; bus_in = DW'($urandom);
          prog_start = 1'($urandom); prog_base = AW'($urandom);
        end else begin
          mo = 1;
        end
        #1;
        vectors++;
        if (halt !== 1'b1 || prog_ready !== 1'b1 || bus_oe !== 1'b0 || prog_done !== 1'b0) begin
          miscompares++;
          $display("FAIL load_flags beat=%0d got halt=%b ready=%b oe=%b done=%b exp 1 1 0 0",
                   i, halt, prog_ready, bus_oe, prog_done);
        end
        tick();
      end
      m_ram[ptr] = ld_data[i]; m_known[ptr] = 1; ptr = ptr + 1'b1;
      exp_cnt = (i + 1 > DEPTH) ? DEPTH : i + 1;
      vectors++;
      if (load_count !== (AW+1)'(exp_cnt)) begin
        miscompares++;
        $display("FAIL load_count beat=%0d got=%0d exp=%0d", i, load_count, exp_cnt);
      end
      if (i + 1 == abort_after) begin
        clear_inputs();
        rst = 0;
        #1;
        vectors++;
        if (halt !== 1'b0 || prog_ready !== 1'b0 || load_count !== '0) begin
          miscompares++;
          $display("FAIL abort_reset got halt=%b ready=%b cnt=%0d exp 0 0 0", halt, prog_ready, load_count);
        end
        tick();
        rst = 1;
        m_mar = '0;
        tick();
        vectors++;
        if (done_cnt != d0 || halt !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_no_done got pulses=%0d halt=%b exp 0 0", done_cnt - d0, halt);
        end
        return;
      end
    end
    clear_inputs();
    mo = 1; prog_start = 1; prog_base = AW'($urandom);
    #1;
    vectors++;
    if (halt !== 1'b1 || prog_ready !== 1'b0 || prog_done !== 1'b1 || bus_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL done_state got halt=%b ready=%b done=%b oe=%b exp 1 0 1 0", halt, prog_ready, prog_done, bus_oe);
    end
    tick();
    clear_inputs();
    #1;
    exp_cnt = (n > DEPTH) ? DEPTH : n;
    vectors++;
    if (halt !== 1'b0 || prog_ready !== 1'b0 || prog_done !== 1'b0 ||
        load_count !== (AW+1)'(exp_cnt) || done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL load_end got halt=%b ready=%b done=%b cnt=%0d pulses=%0d exp 0 0 0 %0d 1",
               halt, prog_ready, prog_done, load_count, done_cnt - d0, exp_cnt);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic oe;
    clear_inputs();
    rst = 0;
    tick(); tick();
    vectors++;
    if (bus_oe !== 0 || halt !== 0 || prog_ready !== 0 || prog_done !== 0 || load_count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got oe=%b halt=%b ready=%b done=%b cnt=%0d exp all 0",
               bus_oe, halt, prog_ready, prog_done, load_count);
    end
    rst = 1;
    m_mar = '0;
    cpu_op(0, 1, 0, 8'hC3);
    read_word(8'h00, d, oe);
    vectors++;
    if (d !== 8'hC3) begin miscompares++; $display("FAIL reset_mar_zero got=%02h exp=c3", d); end
  endtask

  task automatic test_cpu_rw();
    cpu_op(1, 0, 0, 8'h0E);
    cpu_op(0, 1, 0, 8'h5A);
    mo = 1; #1;
    vectors++;
    if (bus_oe !== 1'b1 || bus_out !== 8'h5A) begin
      miscompares++; $display("FAIL cpu_read got oe=%b out=%02h exp 1 5a", bus_oe, bus_out);
    end
    mi = 1; bus_in = 8'hA5; #1;
    vectors++;
    if (bus_out !== 8'h5A) begin miscompares++; $display("FAIL rbw_before got=%02h exp=5a", bus_out); end
    tick();
    m_ram[m_mar] = 8'hA5;
    vectors++;
    if (bus_out !== 8'hA5) begin miscompares++; $display("FAIL rbw_after got=%02h exp=a5", bus_out); end
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    logic oe;
    cpu_op(1, 0, 0, 8'h07);
    cpu_op(0, 1, 0, 8'h66);
    cpu_op(1, 0, 0, 8'h03);
    cpu_op(1, 1, 0, 8'h07);
    mo = 1; #1;
    vectors++;
    if (bus_out !== 8'h66) begin miscompares++; $display("FAIL mai_mi_mar got=%02h exp=66", bus_out); end
    mo = 0;
    read_word(8'h03, d, oe);
    vectors++;
    if (d !== 8'h07) begin miscompares++; $display("FAIL mai_mi_old_addr got=%02h exp=07", d); end
  endtask

  task automatic test_loader_gaps();
    ld_data = '{8'h11, 8'h22, 8'h33};
    run_load(8'h10, 2, 0, 0, 0, '0);
    check_all_known();
  endtask

  task automatic test_wrap();
    ld_data = '{8'hA1, 8'hA2, 8'hA3};
    run_load(8'hFE, 0, 0, 1, 0, '0);
    check_all_known();
  endtask

  task automatic test_reset_midload();
    ld_data = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_load(8'h40, 1, 2, 1, 0, '0);
    ld_data = '{8'hC1, 8'hC2};
    run_load(8'h80, -1, 0, 0, 0, '0);
    check_all_known();
  endtask

  task automatic test_start_with_cpu();
    cpu_op(1, 0, 0, 8'h20);
    ld_data = '{8'hD1};
    run_load(8'h30, 0, 0, 1, 1, 8'h55);
    check_all_known();
  endtask

  task automatic test_saturate();
    ld_data = {};
    for (int i = 0; i < DEPTH + 2; i++) ld_data.push_back(DW'($urandom));
    run_load(8'h00, 0, 0, 0, 0, '0);
  endtask

  task automatic test_idle_valid();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      prog_valid = 1; prog_last = 1; prog_data = DW'($urandom);
      #1;
      vectors++;
      if (halt !== 1'b0 || prog_ready !== 1'b0) begin
        miscompares++; $display("FAIL idle_valid got halt=%b ready=%b exp 0 0", halt, prog_ready);
      end
      tick();
    end
    clear_inputs();
    check_all_known();
  endtask

  task automatic test_random_cpu();
    for (int c = 0; c < 300; c++) begin
      bit a = 1'($urandom), w = 1'($urandom), o = 1'($urandom);
      logic [DW-1:0] d = DW'($urandom);
      mai = a; mi = w; mo = o; bus_in = d;
      #1;
      vectors++;
      if (bus_oe !== o || (m_known[m_mar] && bus_out !== m_ram[m_mar])) begin
        miscompares++;
        $display("FAIL rand_cpu cyc=%0d got oe=%b out=%02h exp oe=%b out=%02h", c, bus_oe, bus_out, o, m_ram[m_mar]);
      end
      tick();
      if (w) begin m_ram[m_mar] = d; m_known[m_mar] = 1; end
      if (a) m_mar = d[AW-1:0];
    end
    clear_inputs();
  endtask

  task automatic test_random_load();
    for (int k = 0; k < 5; k++) begin
      int n = int'($urandom_range(1, 12));
      ld_data = {};
      for (int i = 0; i < n; i++) ld_data.push_back(DW'($urandom));
      run_load(AW'($urandom), -1, 0, 1, 1'($urandom), DW'($urandom));
    end
    check_all_known();
  endtask

  initial begin
    for (int unsigned a = 0; a < DEPTH; a++) begin m_known[a] = 0; m_ram[a] = '0; end
    m_mar = '0;
    test_reset();
    test_cpu_rw();
    test_same_cycle();
    test_loader_gaps();
    test_wrap();
    test_reset_midload();
    test_start_with_cpu();
    test_saturate();
    test_idle_valid();
    test_random_cpu();
    test_random_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
